comm_link_fifo: RTL and testbench
=================================

# comm_link_fifo

Parametrised multi-entry successor to the single-entry comm link buffer: a DEPTH-deep valid/ready FIFO between the link transmit side (tx_*) and the receive side (rx_*). It keeps the one-cycle accept-to-output latency and pass-through-when-full behaviour of the single-entry stage. It adds configurable depth, occupancy reporting, an almost-full flag, synchronous flush and a saturating stall counter for link monitoring. It sits in the same position in the link as the single-entry buffer and is driven by the same UVM agents.

## Interface
- DATA_WIDTH, default comm_link_pkg::COMM_LINK_DATA_WIDTH, payload width in bits.
- DEPTH, default 4, number of entries; any integer ≥ 2, not restricted to powers of two.
- AFULL_THRESH, default DEPTH-1, level at or above which almost_full asserts; legal range 1..DEPTH.
- LVL_W, derived, $clog2(DEPTH+1); not overridable.
---
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_valid  in  1  producer has a word on tx_data.
- tx_ready  out  1  FIFO accepts tx_data this cycle.
- tx_data  in  DATA_WIDTH  write payload.
- rx_valid  out  1  rx_data holds the head word.
- rx_ready  in  1  consumer takes the head word this cycle.
- rx_data  out  DATA_WIDTH  head-of-FIFO payload.
- flush  in  1  synchronous clear of all stored words.
- level  out  LVL_W  current occupancy, 0..DEPTH.
- almost_full  out  1  level ≥ AFULL_THRESH.
- stall_cnt  out  16  number of cycles with tx_valid=1 and tx_ready=0, saturating.

## Operation
- Storage is a DEPTH-entry register array with write pointer wp, read pointer rp and occupancy count.
- Pointers advance modulo DEPTH: at DEPTH-1 they wrap to 0. Non-power-of-2 depths wrap correctly.
- push = tx_valid & tx_ready; pop = rx_valid & rx_ready.
- tx_ready = !flush & ((count < DEPTH) | rx_ready). When full, a same-cycle pop frees the slot. This is a combinational rx_ready→tx_ready path, kept on purpose.
- rx_valid = !flush & (count != 0). rx_data = mem[rp]. No write-to-read bypass.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. Both pointers advance.
  - This holds at count = DEPTH (pass-through) and at 1 ≤ count < DEPTH.
- Simultaneous push/pop at count = 0 is impossible, because rx_valid = 0.
- Flush has priority over push and pop in the same cycle. Next cycle: wp = rp = 0, count = 0, and memory contents are don't-care.
- level = count. almost_full = (count ≥ AFULL_THRESH). Both derive combinationally from count.
- stall_cnt increments on each cycle where tx_valid & !tx_ready, including cycles stalled by flush. It saturates at 0xFFFF. It is cleared only by reset; flush does not clear it.
- rx_data while rx_valid = 0 is don't-care. The bench must not check it.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release by the system):
  - count = 0, wp = rp = 0, stall_cnt = 0, memory cleared to '0.
  - Outputs: rx_valid = 0, rx_data = 0, level = 0, almost_full = 0 (AFULL_THRESH ≥ 1).
  - tx_ready = 1 (flush low).
- Latency: a word pushed at edge N is visible on rx_valid/rx_data after edge N, so it can pop at edge N+1. Minimum latency is 1 cycle.
- Throughput: 1 word/cycle sustained at any occupancy when rx_ready = 1.
- Ordering: strict FIFO. No loss or duplication except through flush or reset.
- Reset asserted mid-transfer: all state clears immediately. An in-flight push or pop in that cycle is discarded.
- level and almost_full update the cycle after the push or pop that changes count.
- The producer must hold tx_data/tx_valid stable until accepted; the FIFO does not check this.

## Test plan
Bench configuration: DATA_WIDTH = 32, DEPTH = 4, AFULL_THRESH = 3.
- **Reset values:** assert rst_n = 0 mid-stream with count = 2 → the same cycle shows rx_valid = 0, level = 0, tx_ready = 1, stall_cnt = 0.
- **Fill and drain:** push 0xA0..0xA3 with rx_ready = 0.
  - level steps 1, 2, 3, 4; almost_full rises when level = 3; tx_ready = 0 at level 4.
  - A 5th tx_valid held 2 cycles gives stall_cnt = 2.
  - Then rx_ready = 1 → pops 0xA0..0xA3 in order and level returns to 0.
- **Full pass-through:** at level 4, hold tx_valid = 1 (data 0xB0) and rx_ready = 1 for one cycle → tx_ready = 1, 0xA0 pops, 0xB0 enters, level stays 4.
- **Streaming wrap:** push 10 words 0x00..0x09 back-to-back with rx_ready = 1 → each word emerges 1 cycle later, level stays ≤ 1, pointers wrap twice, no gaps.
- **Flush priority:** at level 3, assert flush together with tx_valid = 1 and rx_ready = 1.
  - In that cycle: tx_ready = 0 and rx_valid = 0.
  - Next cycle: level = 0, no pop occurred; stall_cnt increments by 1.
- **Saturation:** hold level 4 with tx_valid = 1 for 70000 cycles → stall_cnt = 0xFFFF and stays there.

Source files
------------

// File: rtl/comm_link_fifo.sv
// comm_link_fifo: DEPTH-deep valid/ready link FIFO with one-cycle latency,
// full pass-through, synchronous flush, occupancy and stall monitoring.
`timescale 1ns/1ps

package comm_link_pkg;
  localparam int COMM_LINK_DATA_WIDTH = 32;
endpackage

module comm_link_fifo
  import comm_link_pkg::*;
#(
  parameter int DATA_WIDTH   = COMM_LINK_DATA_WIDTH,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  input  logic [DATA_WIDTH-1:0]        tx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [DATA_WIDTH-1:0]        rx_data,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full,
  output logic [15:0]                  stall_cnt
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF   = LVL_W'(AFULL_THRESH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wp_q, wp_d;
  logic [PTR_W-1:0]      rp_q, rp_d;
  logic [LVL_W-1:0]      cnt_q, cnt_d;
  logic [15:0]           stall_q, stall_d;
  logic                  push, pop;

  // rx_ready feeds tx_ready so a full FIFO can pass a word through
  assign tx_ready = !flush && ((cnt_q < FULL) || rx_ready);
  assign rx_valid = !flush && (cnt_q != '0);
  assign push     = tx_valid && tx_ready;
  assign pop      = rx_valid && rx_ready;

  assign rx_data     = mem_q[rp_q];
  assign level       = cnt_q;
  assign almost_full = (cnt_q >= AF);
  assign stall_cnt   = stall_q;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    if (tx_valid && !tx_ready && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push)
        wp_d = (wp_q == LAST) ? '0 : wp_q + PTR_W'(1);
      if (pop)
        rp_d = (rp_q == LAST) ? '0 : rp_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + LVL_W'(1);
        2'b01:   cnt_d = cnt_q - LVL_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      if (push)
        mem_q[wp_q] <= tx_data;
    end
  end

endmodule

// File: tb/tb_comm_link_fifo.sv
// tb_comm_link_fifo: scoreboard bench for comm_link_fifo with a
// behavioural occupancy/stall model checked every cycle.
`timescale 1ns/1ps

module tb_comm_link_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_valid, tx_ready;
  logic [31:0] tx_data;
  logic        rx_valid, rx_ready;
  logic [31:0] rx_data;
  logic        flush;
  logic [2:0]  level;
  logic        almost_full;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] sb_q[$];
  logic [15:0] m_stall = '0;
  logic [15:0] s0;

  comm_link_fifo #(
    .DATA_WIDTH  (32),
    .DEPTH       (4),
    .AFULL_THRESH(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .flush      (flush),
    .level      (level),
    .almost_full(almost_full),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic tv, input logic [31:0] td,
                       input logic rr, input logic fl);
    tx_valid = tv;
    tx_data  = td;
    rx_ready = rr;
    flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: handshakes derived from scoreboard occupancy, not DUT outputs
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      m_stall = '0;
    end else begin
      int  sz;
      logic m_tr, m_rv, m_push, m_pop;
      sz     = sb_q.size();
      m_tr   = !flush && ((sz < 4) || rx_ready);
      m_rv   = !flush && (sz != 0);
      m_push = tx_valid && m_tr;
      m_pop  = rx_ready && m_rv;
      chk("level", 32'(level), 32'(sz));
      chk("almost_full", 32'(almost_full), 32'(sz >= 3));
      chk("tx_ready", 32'(tx_ready), 32'(m_tr));
      chk("rx_valid", 32'(rx_valid), 32'(m_rv));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      if (tx_valid && !m_tr && m_stall != 16'hFFFF)
        m_stall = m_stall + 16'd1;
      if (flush) begin
        sb_q.delete();
      end else begin
        if (m_pop && sb_q.size() != 0)
          chk("rx_data", rx_data, sb_q.pop_front());
        if (m_push)
          sb_q.push_back(tx_data);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, '0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_level", 32'(level), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_afull", 32'(almost_full), 0);

    // Fill and drain
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hA0 + 32'(i), 0, 0);
      tick();
      chk("fill_level", 32'(level), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 3));
    end
    drive(1, 32'hA4, 0, 0);
    #1 chk("full_tx_ready", 32'(tx_ready), 0);
    s0 = stall_cnt;
    tick();
    tick();
    chk("stall_two", 32'(stall_cnt), 32'(s0 + 16'd2));

    // Full pass-through
    drive(1, 32'hB0, 1, 0);
    #1 chk("pt_tx_ready", 32'(tx_ready), 1);
    chk("pt_head", rx_data, 32'hA0);
    tick();
    chk("pt_level", 32'(level), 4);
    chk("pt_head2", rx_data, 32'hA1);

    drive(0, '0, 1, 0);
    repeat (4) tick();
    chk("drain_level", 32'(level), 0);

    // Streaming with wrap
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'(i), 1, 0);
      tick();
      chk("stream_level", 32'(level <= 3'd1), 1);
      chk("stream_out", rx_data, 32'(i));
    end
    drive(0, '0, 1, 0);
    tick();
    chk("stream_empty", 32'(level), 0);

    // Flush priority
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hC0 + 32'(i), 0, 0);
      tick();
    end
    chk("fl_pre_level", 32'(level), 3);
    drive(1, 32'hC3, 1, 1);
    #1 chk("fl_tx_ready", 32'(tx_ready), 0);
    chk("fl_rx_valid", 32'(rx_valid), 0);
    s0 = stall_cnt;
    tick();
    chk("fl_level", 32'(level), 0);
    chk("fl_stall", 32'(stall_cnt), 32'(s0 + 16'd1));
    drive(0, '0, 0, 0);
    tick();

    // Reset mid-stream with two words stored
    drive(1, 32'hD0, 0, 0);
    tick();
    drive(1, 32'hD1, 0, 0);
    tick();
    chk("mid_level", 32'(level), 2);
    drive(0, '0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_rx_valid", 32'(rx_valid), 0);
    chk("mr_level", 32'(level), 0);
    chk("mr_tx_ready", 32'(tx_ready), 1);
    chk("mr_stall", 32'(stall_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Saturation
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hE0 + 32'(i), 0, 0);
      tick();
    end
    drive(1, 32'hE4, 0, 0);
    repeat (70000) tick();
    chk("sat_stall", 32'(stall_cnt), 32'hFFFF);
    tick();
    chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
    chk("sat_level", 32'(level), 4);

    drive(0, '0, 1, 0);
    repeat (5) tick();
    chk("end_level", 32'(level), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
